dot_accum: RTL and testbench

DOT_ACCUM -- requirements
Module: dot_accum

---
 rtl/dot_accum.sv | 131 +++++++++++++
 tb/tb_dot_accum.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dot_accum.sv
// Two-stage dot-product accumulator: stage 1 sums the parallel lane products of a beat,
// stage 2 accumulates the beat sums per vector. Define DOT_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module dot_accum #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Para_Deg   = 3,
  parameter int unsigned Acc_Width  = 32,
  parameter int unsigned Len_Width  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [Len_Width-1:0]             beat_count,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Para_Deg*2*Data_Width-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [Acc_Width-1:0]             out_data,
  output logic                             out_overflow
);

  localparam int unsigned PW  = 2 * Data_Width;
  localparam int unsigned SW  = PW + $clog2(Para_Deg);
  localparam int unsigned AW1 = Acc_Width + 1;

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_in_ready;
  logic [Len_Width-1:0] r_cnt;
  logic                 r_first;
  logic [SW-1:0]        r_s1_sum;
  logic                 r_s1_valid;
  logic                 r_s1_first;
  logic                 r_s1_last;
  logic [Acc_Width-1:0] r_acc;
  logic                 r_ovf;

  logic [SW-1:0]        w_lane_sum;
  logic [Len_Width-1:0] w_beats;
  logic [Len_Width-1:0] w_remaining;
  logic                 w_last;
  logic                 w_acc;
  logic                 w_hs;
  logic [AW1-1:0]       w_add;

  always_comb begin
    w_lane_sum = '0;
    for (int unsigned i = 0; i < Para_Deg; i++) begin
      w_lane_sum = w_lane_sum + SW'(in_data[i*PW +: PW]);
    end
  end

  assign w_beats     = (beat_count == '0) ? Len_Width'(1) : beat_count;
  assign w_remaining = r_first ? w_beats : r_cnt;
  assign w_last      = (w_remaining == Len_Width'(1));
  assign w_acc       = in_valid && r_in_ready && (r_state == ACC);
  assign w_hs        = (r_state == DONE) && out_ready;
  assign w_add       = {1'b0, r_acc} + AW1'(r_s1_sum);

  // DRAIN starts once the last beat sits in stage 1; in_ready already dropped when it was accepted,
  // so the result appears two edges after the final acceptance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (r_s1_valid && r_s1_last) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ACC;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
      r_first    <= 1'b1;
      r_s1_sum   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == ACC) && !(w_acc && w_last);
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_cnt      <= w_remaining - Len_Width'(1);
        r_first    <= 1'b0;
        r_s1_sum   <= w_lane_sum;
        r_s1_first <= r_first;
        r_s1_last  <= w_last;
      end else if (w_hs) begin
        r_first <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_hs) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_s1_valid) begin
      if (r_s1_first) begin
        r_acc <= Acc_Width'(r_s1_sum);
        r_ovf <= 1'b0;
      end else begin
`ifdef DOT_ACCUM_SAT_EN
        if (w_add[Acc_Width] || r_ovf) begin
          r_acc <= '1;
          r_ovf <= 1'b1;
        end else begin
          r_acc <= w_add[Acc_Width-1:0];
        end
`else
        r_acc <= w_add[Acc_Width-1:0];
        if (w_add[Acc_Width]) r_ovf <= 1'b1;
`endif
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state == DONE);
  assign out_data     = r_acc;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_dot_accum.sv
// Directed self-checking bench for dot_accum: default 32-bit accumulator plus a 20-bit instance for overflow.
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  beat_count;
  logic        in_valid;
  logic [47:0] in_data;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_data;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [19:0] out_data2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot_accum u_dut (
    .clk(clk), .reset(reset), .beat_count(beat_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_ovf)
  );

  dot_accum #(.Acc_Width(20)) u_dut20 (
    .clk(clk), .reset(reset), .beat_count(beat_count), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_overflow(out_ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepts it.
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    in_data  = {c, b, a};
    in_valid = 1'b1;
    for (int n = 0; n < 50 && in_ready !== 1'b1; n++) tick();
    if (in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL beat_wait: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; beat_count = 8'd0; in_data = '0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", out_ovf); end
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; beat_count = 8'd2;
    beat(16'd1, 16'd2, 16'd3);
    beat(16'd4, 16'd5, 16'd6);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_drain_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'd21) begin n_err++; $display("FAIL basic_data: got %0d want 21", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b want 0", out_ovf); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_hold();
    out_ready = 1'b0; beat_count = 8'd2;
    beat(16'd1, 16'd2, 16'd3);
    beat(16'd4, 16'd5, 16'd6);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== 32'd21) begin n_err++; $display("FAIL hold_data[%0d]: got %0d want 21", i, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
      in_valid = 1'b1;
      in_data  = {16'd100 + 16'(i), 16'd200, 16'd300};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL hold_acc_clear: got %0d want 0", out_data); end
  endtask

  task automatic test_zero_count();
    out_ready = 1'b1; beat_count = 8'd0;
    beat(16'd7, 16'd0, 16'd0);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_early_valid: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'd7) begin n_err++; $display("FAIL zero_data: got %0d want 7", out_data); end
    tick();
  endtask

  task automatic test_overflow();
    logic [19:0] exp20;
`ifdef DOT_ACCUM_SAT_EN
    exp20 = 20'd1048575;
`else
    exp20 = 20'd131054;
`endif
    out_ready = 1'b1; beat_count = 8'd6;
    for (int i = 0; i < 6; i++) beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
    tick(); tick();
    n_cmp++; if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL ovf_valid20: got %b want 1", out_valid2); end
    n_cmp++; if (out_data2 !== exp20) begin n_err++; $display("FAIL ovf_data20: got %0d want %0d", out_data2, exp20); end
    n_cmp++; if (out_ovf2 !== 1'b1) begin n_err++; $display("FAIL ovf_flag20: got %b want 1", out_ovf2); end
    n_cmp++; if (out_data !== 32'd1179630) begin n_err++; $display("FAIL ovf_data32: got %0d want 1179630", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_flag32: got %b want 0", out_ovf); end
    tick();
    n_cmp++; if (out_ovf2 !== 1'b0) begin n_err++; $display("FAIL ovf_clear20: got %b want 0", out_ovf2); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int at;
    logic [31:0] seen;
    out_ready = 1'b1; beat_count = 8'd4;
    beat(16'd9, 16'd9, 16'd9);
    beat(16'd9, 16'd9, 16'd9);
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    reset = 1'b1;
    tick();
    beat_count = 8'd1;
    beat(16'd1, 16'd1, 16'd1);
    pulses = 0; at = -1; seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid === 1'b1) begin pulses++; seen = out_data; if (at < 0) at = i; end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL mid_pulses: got %0d want 1", pulses); end
    n_cmp++; if (seen !== 32'd3) begin n_err++; $display("FAIL mid_data: got %0d want 3", seen); end
    n_cmp++; if (at != 1) begin n_err++; $display("FAIL mid_latency: got cycle %0d want 1", at); end
  endtask

  task automatic test_gaps();
    int pulses;
    logic [31:0] seen;
    out_ready = 1'b1; beat_count = 8'd3;
    beat(16'd10, 16'd20, 16'd30);
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_ready1: got %b want 1", in_ready); end
    beat(16'd1, 16'd2, 16'd3);
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_ready2: got %b want 1", in_ready); end
    beat(16'd100, 16'd0, 16'd5);
    pulses = 0; seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid === 1'b1) begin pulses++; seen = out_data; end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
    n_cmp++; if (seen !== 32'd171) begin n_err++; $display("FAIL gap_data: got %0d want 171", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_zero_count();
    test_overflow();
    test_reset_mid();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
